// File: rtl/neural_layer_seq.sv
// Sequential fully-connected float layer: MOD_COUNT time-shared MAC units walk the
// neurons group by group, accumulating bias + sum(in*w) in single precision, then apply the activation.
module neural_layer_seq #(
    parameter int IN_SIZE    = 25,
    parameter int OUT_SIZE   = 20,
    parameter int ACTIVATION = 1,
    parameter int MOD_COUNT  = 10
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [32*IN_SIZE-1:0]           in,
    input  logic [32*IN_SIZE*OUT_SIZE-1:0]  weights,
    input  logic [32*OUT_SIZE-1:0]          bias,
    output logic [32*OUT_SIZE-1:0]          result,
    output logic                            done
);

    localparam int GROUPS = (OUT_SIZE + MOD_COUNT - 1) / MOD_COUNT;
    localparam int KW     = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1;
    localparam int GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(IN_SIZE - 1);
    localparam logic [GW-1:0] G_LAST = GW'(GROUPS - 1);
    localparam logic [31:0]   QNAN   = 32'h7FC00000;

    typedef enum logic [2:0] {S_START, S_INIT, S_MAC, S_WRITE, S_DONE} state_t;

    state_t                            r_state;
    logic [GW-1:0]                     r_group;
    logic [KW-1:0]                     r_k;
    logic                              r_done;
    logic [32*OUT_SIZE-1:0]            r_result;
    logic [32*IN_SIZE-1:0]             r_in_snap;
    logic [32*IN_SIZE*OUT_SIZE-1:0]    r_w_snap;
    logic [32*OUT_SIZE-1:0]            r_b_snap;
    logic [31:0]                       r_acc [MOD_COUNT];

    logic [31:0] w_x;
    int          w_nidx      [MOD_COUNT];
    int          w_nsel      [MOD_COUNT];
    logic        w_active    [MOD_COUNT];
    logic [31:0] w_bias_live [MOD_COUNT];
    logic [31:0] w_bias_snap [MOD_COUNT];
    logic [31:0] w_mac       [MOD_COUNT];
    logic        w_changed;

    function automatic logic is_nan(input logic [31:0] v);
        return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
    endfunction

    function automatic logic is_inf(input logic [31:0] v);
        return (v[30:23] == 8'hFF) && (v[22:0] == 23'd0);
    endfunction

    // sig: bit 26 is the 1.0 position, bits 2:0 are guard/round/sticky; e is the biased exponent.
    function automatic logic [31:0] round_pack(input logic sgn, input logic signed [11:0] e,
                                               input logic [26:0] sig);
        logic [26:0] s;
        logic        stk;
        logic        up;
        logic [7:0]  eb;
        logic [30:0] r;
        int          sh;
        if (e >= 12'sd255) return {sgn, 8'hFF, 23'd0};
        if (e <= 12'sd0) begin
            sh = 1 - int'(e);
            if (sh >= 27) begin
                s   = '0;
                stk = |sig;
            end else begin
                s   = sig >> sh;
                stk = |(sig & ((27'd1 << sh) - 27'd1));
            end
            eb = 8'd0;
        end else begin
            s   = sig;
            stk = 1'b0;
            eb  = 8'(e - 12'sd1);
        end
        up = s[2] & (s[1] | s[0] | stk | s[3]);
        // The hidden bit and any rounding carry ripple straight into the exponent field.
        r = {eb, 23'd0} + {7'd0, s[26:3]} + 31'(up);
        if (r[30:23] == 8'hFF) return {sgn, 8'hFF, 23'd0};
        return {sgn, r};
    endfunction

    // w: bit 48 is the 1.0 position at biased exponent e; w must be nonzero.
    function automatic logic [31:0] norm_round(input logic sgn, input logic signed [11:0] e,
                                               input logic [49:0] w);
        int                 lz;
        logic [49:0]        ws;
        logic signed [11:0] en;
        lz = 0;
        for (int i = 0; i < 50; i++) begin
            if (w[i]) lz = 49 - i;
        end
        ws = w << lz;
        en = e + 12'sd1 - $signed(12'(lz));
        return round_pack(sgn, en, {ws[49:24], |ws[23:0]});
    endfunction

    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic               sg;
        logic [7:0]         ea;
        logic [7:0]         eb;
        logic [47:0]        p;
        logic signed [11:0] e;
        sg = a[31] ^ b[31];
        if (is_nan(a) || is_nan(b)) return QNAN;
        if (is_inf(a) || is_inf(b)) begin
            if (a[30:0] == 31'd0 || b[30:0] == 31'd0) return QNAN;
            return {sg, 8'hFF, 23'd0};
        end
        if (a[30:0] == 31'd0 || b[30:0] == 31'd0) return {sg, 31'd0};
        ea = (a[30:23] == 8'd0) ? 8'd1 : a[30:23];
        eb = (b[30:23] == 8'd0) ? 8'd1 : b[30:23];
        p  = 48'({a[30:23] != 8'd0, a[22:0]}) * 48'({b[30:23] != 8'd0, b[22:0]});
        e  = $signed({4'd0, ea}) + $signed({4'd0, eb}) - 12'sd127;
        return norm_round(sg, e, {p, 2'b00});
    endfunction

    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] x;
        logic [31:0] y;
        logic [7:0]  ex;
        logic [7:0]  ey;
        logic [49:0] wx;
        logic [49:0] wy;
        logic [49:0] ws;
        int          d;
        if (is_nan(a) || is_nan(b)) return QNAN;
        if (is_inf(a) && is_inf(b) && (a[31] != b[31])) return QNAN;
        if (is_inf(a)) return a;
        if (is_inf(b)) return b;
        if (a[30:0] >= b[30:0]) begin
            x = a;
            y = b;
        end else begin
            x = b;
            y = a;
        end
        ex = (x[30:23] == 8'd0) ? 8'd1 : x[30:23];
        ey = (y[30:23] == 8'd0) ? 8'd1 : y[30:23];
        wx = {1'b0, x[30:23] != 8'd0, x[22:0], 25'd0};
        wy = {1'b0, y[30:23] != 8'd0, y[22:0], 25'd0};
        d  = int'(ex) - int'(ey);
        if (d >= 50) wy = {49'd0, |wy};
        else if (d > 0) wy = (wy >> d) | {49'd0, |(wy & ((50'd1 << d) - 50'd1))};
        ws = (x[31] == y[31]) ? wx + wy : wx - wy;
        // Exact cancellation rounds to +0 unless both operands were negative.
        if (ws == '0) return {x[31] & y[31], 31'd0};
        return norm_round(x[31], $signed({4'd0, ex}), ws);
    endfunction

    function automatic logic [31:0] act(input logic [31:0] v);
        if (ACTIVATION == 1 && v[31]) return 32'h00000000;
        return v;
    endfunction

    always_comb begin
        w_x = r_in_snap[32*int'(r_k) +: 32];
        for (int u = 0; u < MOD_COUNT; u++) begin
            w_nidx[u]      = int'(r_group) * MOD_COUNT + u;
            w_active[u]    = (w_nidx[u] < OUT_SIZE);
            w_nsel[u]      = w_active[u] ? w_nidx[u] : 0;
            w_bias_live[u] = bias[32*w_nsel[u] +: 32];
            w_bias_snap[u] = r_b_snap[32*w_nsel[u] +: 32];
            w_mac[u]       = fadd(r_acc[u],
                                  fmul(w_x, r_w_snap[32*(w_nsel[u]*IN_SIZE + int'(r_k)) +: 32]));
        end
        w_changed = (in != r_in_snap) || (weights != r_w_snap) || (bias != r_b_snap);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_START;
            r_group   <= '0;
            r_k       <= '0;
            r_done    <= 1'b0;
            r_result  <= '0;
            r_in_snap <= '0;
            r_w_snap  <= '0;
            r_b_snap  <= '0;
            for (int u = 0; u < MOD_COUNT; u++) r_acc[u] <= '0;
        end else begin
            case (r_state)
                // Group is always 0 here, so the live bias feeds group 0 while the snapshot loads.
                S_START: begin
                    r_in_snap <= in;
                    r_w_snap  <= weights;
                    r_b_snap  <= bias;
                    for (int u = 0; u < MOD_COUNT; u++) r_acc[u] <= w_bias_live[u];
                    r_k     <= '0;
                    r_done  <= 1'b0;
                    r_state <= S_MAC;
                end
                S_INIT: begin
                    for (int u = 0; u < MOD_COUNT; u++) r_acc[u] <= w_bias_snap[u];
                    r_k     <= '0;
                    r_state <= S_MAC;
                end
                S_MAC: begin
                    for (int u = 0; u < MOD_COUNT; u++) r_acc[u] <= w_mac[u];
                    if (r_k == K_LAST) r_state <= S_WRITE;
                    else r_k <= r_k + 1'b1;
                end
                S_WRITE: begin
                    for (int u = 0; u < MOD_COUNT; u++) begin
                        if (w_active[u]) r_result[32*w_nsel[u] +: 32] <= act(r_acc[u]);
                    end
                    if (r_group == G_LAST) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_group <= r_group + 1'b1;
                        r_state <= S_INIT;
                    end
                end
                S_DONE: begin
                    if (w_changed) begin
                        r_state <= S_START;
                        r_done  <= 1'b0;
                        r_group <= '0;
                    end
                end
                default: r_state <= S_START;
            endcase
        end
    end

    assign result = r_result;
    assign done   = r_done;

endmodule

// File: tb/tb_neural_layer_seq.sv
// Bench for neural_layer_seq: directed plan cases plus randomized vectors against a
// real-arithmetic reference (each float op rounded once to single precision).
module tb_neural_layer_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic [63:0]  s_in;
    logic [191:0] s_w;
    logic [95:0]  s_b;
    logic [95:0]  res0, res1, res2, res3;
    logic         d0, d1, d2, d3, d4;
    logic [32*25-1:0]  big_in;
    logic [32*500-1:0] big_w;
    logic [32*20-1:0]  big_b;
    logic [32*20-1:0]  res4;

    neural_layer_seq #(.IN_SIZE(2), .OUT_SIZE(3), .ACTIVATION(0), .MOD_COUNT(2)) u0 (
        .clk(clk), .rst_n(rst_n), .in(s_in), .weights(s_w), .bias(s_b), .result(res0), .done(d0));
    neural_layer_seq #(.IN_SIZE(2), .OUT_SIZE(3), .ACTIVATION(1), .MOD_COUNT(2)) u1 (
        .clk(clk), .rst_n(rst_n), .in(s_in), .weights(s_w), .bias(s_b), .result(res1), .done(d1));
    neural_layer_seq #(.IN_SIZE(2), .OUT_SIZE(3), .ACTIVATION(0), .MOD_COUNT(1)) u2 (
        .clk(clk), .rst_n(rst_n), .in(s_in), .weights(s_w), .bias(s_b), .result(res2), .done(d2));
    neural_layer_seq #(.IN_SIZE(2), .OUT_SIZE(3), .ACTIVATION(0), .MOD_COUNT(3)) u3 (
        .clk(clk), .rst_n(rst_n), .in(s_in), .weights(s_w), .bias(s_b), .result(res3), .done(d3));
    neural_layer_seq #(.IN_SIZE(25), .OUT_SIZE(20), .ACTIVATION(1), .MOD_COUNT(10)) u4 (
        .clk(clk), .rst_n(rst_n), .in(big_in), .weights(big_w), .bias(big_b), .result(res4), .done(d4));

    logic [31:0] t_in [2];
    logic [31:0] t_w  [3][2];
    logic [31:0] t_b  [3];
    logic [31:0] e1   [3];
    int n_checks;
    int n_errors;
    int lat [5];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic real f2r(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:0] == 31'd0) d = {f[31], 63'd0};
        else d = {f[31], 11'(int'(f[30:23]) - 127 + 1023), f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        logic [24:0] m;
        int          e;
        d = $realtobits(r);
        if (d[62:52] == 11'd0) return {d[63], 31'd0};
        e = int'(d[62:52]) - 1023 + 127;
        m = {2'b01, d[51:29]};
        if (d[28] && ((|d[27:0]) || m[0])) m = m + 25'd1;
        if (m[24]) begin
            m = m >> 1;
            e++;
        end
        return {d[63], 8'(e), m[22:0]};
    endfunction

    function automatic logic [31:0] ref_out(input int j, input bit relu);
        logic [31:0] a;
        a = t_b[j];
        for (int i = 0; i < 2; i++)
            a = r2f(f2r(a) + f2r(r2f(f2r(t_in[i]) * f2r(t_w[j][i]))));
        if (relu && a[31]) return 32'h0;
        return a;
    endfunction

    function automatic logic [31:0] rnd_f();
        logic [31:0] v;
        v[31]    = 1'($urandom_range(0, 1));
        v[30:23] = 8'($urandom_range(120, 134));
        v[22:0]  = 23'($urandom);
        return v;
    endfunction

    task automatic drive();
        for (int i = 0; i < 2; i++) s_in[32*i +: 32] = t_in[i];
        for (int j = 0; j < 3; j++) begin
            s_b[32*j +: 32] = t_b[j];
            for (int i = 0; i < 2; i++) s_w[32*(j*2+i) +: 32] = t_w[j][i];
        end
    endtask

    task automatic randomize_data();
        for (int i = 0; i < 2; i++) t_in[i] = rnd_f();
        for (int j = 0; j < 3; j++) begin
            t_b[j] = rnd_f();
            for (int i = 0; i < 2; i++) t_w[j][i] = rnd_f();
        end
        drive();
    endtask

    task automatic wait_all_done();
        int run;
        run = 0;
        for (int c = 0; c < 200 && run < 2; c++) begin
            @(posedge clk);
            #1;
            if (d0 && d1 && d2 && d3) run++;
            else run = 0;
        end
        check("all_done_stable", 32'(run >= 2), 32'd1);
    endtask

    task automatic check_all(input string tag);
        for (int j = 0; j < 3; j++) begin
            check($sformatf("%s_u0_n%0d", tag, j), res0[32*j +: 32], ref_out(j, 1'b0));
            check($sformatf("%s_u1_n%0d", tag, j), res1[32*j +: 32], ref_out(j, 1'b1));
            check($sformatf("%s_u2_n%0d", tag, j), res2[32*j +: 32], ref_out(j, 1'b0));
            check($sformatf("%s_u3_n%0d", tag, j), res3[32*j +: 32], ref_out(j, 1'b0));
        end
    endtask

    task automatic check_big(input string tag);
        for (int j = 0; j < 20; j++)
            check($sformatf("%s_n%0d", tag, j), res4[32*j +: 32], 32'h41D00000);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b1;
        t_in[0] = 32'h3F800000;
        t_in[1] = 32'h40000000;
        t_b[0]  = 32'h00000000;
        t_b[1]  = 32'h3F800000;
        t_b[2]  = 32'hC0400000;
        for (int j = 0; j < 3; j++)
            for (int i = 0; i < 2; i++) t_w[j][i] = 32'h3F000000;
        drive();
        for (int i = 0; i < 25; i++)  big_in[32*i +: 32] = 32'h3F800000;
        for (int i = 0; i < 500; i++) big_w[32*i +: 32]  = 32'h3F800000;
        for (int j = 0; j < 20; j++)  big_b[32*j +: 32]  = 32'h3F800000;

        #2 rst_n = 1'b0;
        #1;
        for (int j = 0; j < 3; j++) check($sformatf("rst_res_n%0d", j), res0[32*j +: 32], 32'h0);
        check("rst_done", 32'(d0), 32'd0);
        check("rst_big_res0", res4[31:0], 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < 5; k++) lat[k] = 0;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk);
            #1;
            if (d0 && lat[0] == 0) lat[0] = c;
            if (d1 && lat[1] == 0) lat[1] = c;
            if (d2 && lat[2] == 0) lat[2] = c;
            if (d3 && lat[3] == 0) lat[3] = c;
            if (d4 && lat[4] == 0) lat[4] = c;
        end
        check("lat_mc2", 32'(lat[0]), 32'd8);
        check("lat_mc2_relu", 32'(lat[1]), 32'd8);
        check("lat_mc1", 32'(lat[2]), 32'd12);
        check("lat_mc3", 32'(lat[3]), 32'd4);
        check("lat_default", 32'(lat[4]), 32'd54);

        check("plan_id_n0", res0[31:0], 32'h3FC00000);
        check("plan_id_n1", res0[63:32], 32'h40200000);
        check("plan_id_n2", res0[95:64], 32'hBFC00000);
        check("plan_relu_n0", res1[31:0], 32'h3FC00000);
        check("plan_relu_n1", res1[63:32], 32'h40200000);
        check("plan_relu_n2", res1[95:64], 32'h00000000);
        check("plan_mc1_vs_mc2", res2, res0[31:0]);
        check("plan_mc1_all", {res2 == 96'hBFC00000_40200000_3FC00000}, 32'd1);
        check("plan_mc3_all", {res3 == 96'hBFC00000_40200000_3FC00000}, 32'd1);
        check_big("plan_default");

        @(negedge clk);
        t_in[0] = 32'hBF800000;
        drive();
        @(posedge clk);
        #1;
        check("done_fall", 32'(d0), 32'd0);
        wait_all_done();
        check("chg_n0", res0[31:0], 32'h3F000000);
        check("chg_n1", res0[63:32], 32'h3FC00000);
        check("chg_n2", res0[95:64], 32'hC0200000);
        check_all("chg");

        @(negedge clk);
        randomize_data();
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        for (int j = 0; j < 3; j++) check($sformatf("midrst_res_n%0d", j), res0[32*j +: 32], 32'h0);
        check("midrst_done", 32'(d0), 32'd0);
        check("midrst_done_big", 32'(d4), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_all_done();
        check_all("post_rst");

        for (int it = 0; it < 8; it++) begin
            @(negedge clk);
            randomize_data();
            for (int j = 0; j < 3; j++) e1[j] = ref_out(j, 1'b0);
            @(posedge clk);
            #1;
            check($sformatf("rnd%0d_done_fall", it), 32'(d0), 32'd0);
            if (it % 2 == 1) begin
                repeat (2) @(posedge clk);
                @(negedge clk);
                randomize_data();
                for (int c = 0; c < 40 && !d0; c++) begin
                    @(posedge clk);
                    #1;
                end
                for (int j = 0; j < 3; j++)
                    check($sformatf("rnd%0d_stale_n%0d", it, j), res0[32*j +: 32], e1[j]);
            end
            wait_all_done();
            check_all($sformatf("rnd%0d", it));
        end

        for (int c = 0; c < 100 && !d4; c++) begin
            @(posedge clk);
            #1;
        end
        check("final_big_done", 32'(d4), 32'd1);
        check_big("final_default");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/neural_layer_seq.md
Name: neural_layer_seq

Overview:
- Sequential fully-connected neural layer over IEEE-754 single-precision floats: result[j] = act(bias[j] + sum_i in[i]*weights[j][i]).
- Uses MOD_COUNT time-shared multiply-accumulate units, trading latency for area.
- Sits between network input and the combinational parallel layers; `done` signals that `result` is valid.
- Float arithmetic comes from the codebase's combinational single-precision multiplier and adder (round-to-nearest-even). This block is the sequencer, datapath registers and activation only.

Parameters:
- IN_SIZE, 25, number of inputs per neuron (>=1).
- OUT_SIZE, 20, number of neurons/outputs (>=1).
- ACTIVATION, 1, 0 = identity, 1 = ReLU.
- MOD_COUNT, 10, number of parallel MAC units (1..OUT_SIZE).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in  in  32*IN_SIZE  input vector; element i at [32*i +: 32].
- weights  in  32*IN_SIZE*OUT_SIZE  weight of neuron j, input i at [32*(j*IN_SIZE+i) +: 32].
- bias  in  32*OUT_SIZE  bias of neuron j at [32*j +: 32].
- result  out  32*OUT_SIZE  activated output j at [32*j +: 32], registered.
- done  out  1  high while result corresponds to the current inputs.

Behaviour:
- Reset (async, rst_n=0): result=0, done=0, state=START, group=0, snapshot registers cleared. All outputs are registered.
- G = ceil(OUT_SIZE/MOD_COUNT) groups. Group g covers neurons g*MOD_COUNT .. min(OUT_SIZE, (g+1)*MOD_COUNT)-1. Units beyond OUT_SIZE in the last group are idle; their results are discarded.
- START (1 cycle):
  - Snapshot in/weights/bias.
  - acc[u] <= bias[neuron of u].
  - k <= 0; done <= 0.
- MAC (IN_SIZE cycles): each cycle, acc[u] <= acc[u] + in[k]*weights[neuron][k] (multiply then add, two roundings); k++.
- WRITE (1 cycle):
  - result[neuron] <= act(acc[u]) for each active unit.
  - If last group: go to DONE, done <= 1. Otherwise group++ and return to START's accumulator init (bias load, k=0) without re-snapshotting.
- Per group: 1 init + IN_SIZE MAC + 1 write cycles. done rises G*(IN_SIZE+2) clock edges after the first START edge.
- DONE: result and done hold. If in, weights or bias differ from the snapshot, go to START next edge: done drops, recomputation begins.
- Input change mid-computation: the snapshot is used for the whole pass, so changes are ignored until DONE, which then immediately restarts.
- Outputs of groups not yet rewritten keep their previous values during a pass; only done qualifies result.
- ReLU: sign bit 1 (including -0, negative inf, negative-signed NaN) -> 32'h00000000; otherwise pass through unchanged. Identity passes acc unchanged.
- NaN/inf propagate per adder/multiplier rules. Denormal handling follows the float library.
- Reset mid-operation aborts immediately; after release, computation restarts from START.

Test Plan:
- IN_SIZE=2, OUT_SIZE=3, MOD_COUNT=2, ACTIVATION=0, in={1.0,2.0} (3F800000, 40000000), all weights 0.5 (3F000000), biases {0,1.0,-3.0}:
  - -> done rises 8 edges after reset release.
  - -> result = {3FC00000, 40200000, BFC00000} (1.5, 2.5, -1.5).
- Same stimulus, ACTIVATION=1 -> result[2]=00000000, others unchanged.
- MOD_COUNT=1 vs MOD_COUNT=OUT_SIZE=3 on the same data -> identical results; done after 12 vs 4 cycles.
- After done, change in[0] to -1.0 (BF800000):
  - -> done falls the next edge.
  - -> identity result = {3F000000, 3FC00000, C0200000} when done re-rises.
- Assert rst_n=0 mid-MAC -> result=0 and done=0 asynchronously; after release, the full pass completes with correct values.
- Default parameters (25/20/10) with all inputs, weights and biases = 1.0, ReLU:
  - -> every output = 26.0 (41D00000).
  - -> done after 2*27=54 cycles.
